// File: rtl/id_ex_stage_pkg.sv
// Shared encodings for the ID/EX boundary: instruction types, write-back
// selects and the EX control word together with its bubble value.
package id_ex_stage_pkg;

  localparam logic [2:0] ITYPE_R = 3'b000;
  localparam logic [2:0] ITYPE_I = 3'b001;
  localparam logic [2:0] ITYPE_S = 3'b010;
  localparam logic [2:0] ITYPE_B = 3'b011;
  localparam logic [2:0] ITYPE_U = 3'b100;
  localparam logic [2:0] ITYPE_J = 3'b101;

  localparam logic [1:0] WB_MEM  = 2'b00;
  localparam logic [1:0] WB_ALU  = 2'b01;
  localparam logic [1:0] WB_PC4  = 2'b10;
  localparam logic [1:0] WB_NONE = 2'b11;

  typedef struct packed {
    logic       valid;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic [2:0] funct3;
    logic [2:0] instruction_type;
    logic       a_select;
    logic       b_select;
    logic [3:0] alu_select;
    logic       regfile_enable;
    logic [1:0] wb_sel;
    logic       mem_rw;
    logic       d_jump;
  } ex_ctrl_t;

  // A bubble writes nothing, stores nothing and never redirects.
  localparam ex_ctrl_t BUBBLE = '{wb_sel: WB_NONE, default: '0};

endpackage

// File: rtl/id_ex_stage_load_use_detect.sv
// Combinational load-use detector: the instruction in ID reads the register
// that a load currently in EX is about to write.
module id_ex_stage_load_use_detect
  import id_ex_stage_pkg::*;
(
  input  logic       id_valid,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic [2:0] id_instruction_type,
  input  logic       id_b_select,
  input  logic       ex_valid,
  input  logic       ex_redirect,
  input  logic       ex_regfile_enable,
  input  logic [1:0] ex_wb_sel,
  input  logic [4:0] ex_rd,
  output logic       load_use
);

  logic uses_rs1;
  logic uses_rs2;
  logic ex_is_load;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    uses_rs1 = 1'b0;
    uses_rs2 = 1'b0;
    case (id_instruction_type)
      ITYPE_R: begin
        uses_rs1 = 1'b1;
        uses_rs2 = ~id_b_select;
      end
      ITYPE_I: uses_rs1 = 1'b1;
      ITYPE_S, ITYPE_B: begin
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
      end
      default: ;
    endcase
  end

  // x0 is never a real dependency, and a squashed ID instruction cannot stall.
  assign ex_is_load = ex_regfile_enable && (ex_wb_sel == WB_MEM) && (ex_rd != 5'd0);
  assign load_use   = id_valid && ex_valid && !ex_redirect && ex_is_load &&
                      ((uses_rs1 && (id_rs1 == ex_rd)) || (uses_rs2 && (id_rs2 == ex_rd)));

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, EX-redirect squash,
// data-memory freeze and a saturating bubble counter.
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [XLEN-1:0]  id_pc,
  input  logic [XLEN-1:0]  id_rs1_data,
  input  logic [XLEN-1:0]  id_rs2_data,
  input  logic [XLEN-1:0]  id_imm,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic [4:0]       id_rd,
  input  logic [2:0]       id_funct3,
  input  logic [2:0]       id_instruction_type,
  input  logic             id_a_select,
  input  logic             id_b_select,
  input  logic [3:0]       id_alu_select,
  input  logic             id_regfile_enable,
  input  logic [1:0]       id_wb_sel,
  input  logic             id_mem_rw,
  input  logic             id_d_jump,
  input  logic             ex_redirect,
  input  logic             mem_stall,
  output logic             ex_valid,
  output logic [XLEN-1:0]  ex_pc,
  output logic [XLEN-1:0]  ex_rs1_data,
  output logic [XLEN-1:0]  ex_rs2_data,
  output logic [XLEN-1:0]  ex_imm,
  output logic [4:0]       ex_rs1,
  output logic [4:0]       ex_rs2,
  output logic [4:0]       ex_rd,
  output logic [2:0]       ex_funct3,
  output logic [2:0]       ex_instruction_type,
  output logic             ex_a_select,
  output logic             ex_b_select,
  output logic [3:0]       ex_alu_select,
  output logic             ex_regfile_enable,
  output logic [1:0]       ex_wb_sel,
  output logic             ex_mem_rw,
  output logic             ex_d_jump,
  output logic             hold_if_id,
  output logic             flush_if_id,
  output logic [CNT_W-1:0] bubble_count
);

  ex_ctrl_t              ctrl_q, ctrl_d, id_ctrl;
  logic [4*XLEN-1:0]     data_q, data_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  load_use;

  assign id_ctrl = '{valid: id_valid, rs1: id_rs1, rs2: id_rs2, rd: id_rd,
                     funct3: id_funct3, instruction_type: id_instruction_type,
                     a_select: id_a_select, b_select: id_b_select,
                     alu_select: id_alu_select, regfile_enable: id_regfile_enable,
                     wb_sel: id_wb_sel, mem_rw: id_mem_rw, d_jump: id_d_jump};

  id_ex_stage_load_use_detect u_load_use_detect (
    .id_valid            (id_valid),
    .id_rs1              (id_rs1),
    .id_rs2              (id_rs2),
    .id_instruction_type (id_instruction_type),
    .id_b_select         (id_b_select),
    .ex_valid            (ctrl_q.valid),
    .ex_redirect         (ex_redirect),
    .ex_regfile_enable   (ctrl_q.regfile_enable),
    .ex_wb_sel           (ctrl_q.wb_sel),
    .ex_rd               (ctrl_q.rd),
    .load_use            (load_use)
  );

  always_comb begin
    ctrl_d  = ctrl_q;
    data_d  = data_q;
    count_d = count_q;
    if (mem_stall) begin
      // Frozen pipe: everything holds, including a pending hazard.
    end else if (ex_redirect || load_use || !id_valid) begin
      ctrl_d = BUBBLE;
      data_d = '0;
      if (load_use && count_q != {CNT_W{1'b1}}) count_d = count_q + 1'b1;
    end else begin
      ctrl_d = id_ctrl;
      data_d = {id_pc, id_rs1_data, id_rs2_data, id_imm};
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_q  <= BUBBLE;
      data_q  <= '0;
      count_q <= '0;
    end else begin
      ctrl_q  <= ctrl_d;
      data_q  <= data_d;
      count_q <= count_d;
    end
  end

  assign hold_if_id  = mem_stall | load_use;
  assign flush_if_id = ex_redirect & ~mem_stall;

  assign {ex_pc, ex_rs1_data, ex_rs2_data, ex_imm} = data_q;
  assign ex_valid            = ctrl_q.valid;
  assign ex_rs1              = ctrl_q.rs1;
  assign ex_rs2              = ctrl_q.rs2;
  assign ex_rd               = ctrl_q.rd;
  assign ex_funct3           = ctrl_q.funct3;
  assign ex_instruction_type = ctrl_q.instruction_type;
  assign ex_a_select         = ctrl_q.a_select;
  assign ex_b_select         = ctrl_q.b_select;
  assign ex_alu_select       = ctrl_q.alu_select;
  assign ex_regfile_enable   = ctrl_q.regfile_enable;
  assign ex_wb_sel           = ctrl_q.wb_sel;
  assign ex_mem_rw           = ctrl_q.mem_rw;
  assign ex_d_jump           = ctrl_q.d_jump;
  assign bubble_count        = count_q;

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline boundary of the 5-stage core. It registers the control unit's decoded control word plus the operands, immediate, PC and register indices into the EX stage.
- Contains load-use hazard detection. On a hazard it inserts bubbles and holds IF/ID.
- Applies the EX redirect flush (taken branch or jump) and the data-memory freeze.
- Counts inserted bubbles for performance monitoring.

Parameters:
XLEN, 32, datapath width for pc/operand/immediate fields
CNT_W, 32, width of the saturating bubble counter

Ports:
clk  in  1  clock, rising-edge
rst  in  1  asynchronous, active-high reset
id_valid  in  1  ID holds a real instruction
id_pc  in  XLEN  PC of the ID instruction
id_rs1_data  in  XLEN  regfile read port 1
id_rs2_data  in  XLEN  regfile read port 2
id_imm  in  XLEN  sign-extended immediate
id_rs1  in  5  source register 1 index
id_rs2  in  5  source register 2 index
id_rd  in  5  destination register index
id_funct3  in  3  funct3 (branch compare / load-store size)
id_instruction_type  in  3  R/I/S/B/U/J code from the control unit
id_a_select  in  1  0=reg, 1=PC
id_b_select  in  1  0=reg, 1=imm
id_alu_select  in  4  ALU operation
id_regfile_enable  in  1  write-back enable
id_wb_sel  in  2  00 mem, 01 ALU, 10 PC+4, 11 none
id_mem_rw  in  1  1 = store
id_d_jump  in  1  JAL/JALR
ex_redirect  in  1  EX resolved a taken branch or jump this cycle
mem_stall  in  1  data memory not ready; freeze the pipe
ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm, ex_rs1, ex_rs2, ex_rd, ex_funct3, ex_instruction_type, ex_a_select, ex_b_select, ex_alu_select, ex_regfile_enable, ex_wb_sel, ex_mem_rw, ex_d_jump  out  (same widths as id_*)  registered EX copies
hold_if_id  out  1  IF/ID and PC must not advance
flush_if_id  out  1  IF/ID must become a bubble
bubble_count  out  CNT_W  number of load-use bubbles inserted, saturating

Behaviour:
- Reset (async, immediate):
  - All ex_* outputs are 0, except ex_wb_sel=2'b11.
  - bubble_count=0.
  - hold_if_id and flush_if_id are combinational and evaluate to 0 while ex_valid=0 and the inputs are idle.
- Bubble value: identical to the reset value. This guarantees ex_regfile_enable=0, ex_mem_rw=0 and ex_d_jump=0.
- Load-use hazard (combinational), load_use = all of:
  - id_valid & ex_valid & ~ex_redirect
  - ex_regfile_enable & (ex_wb_sel==00) & (ex_rd!=0)
  - a source match: (uses_rs1 & id_rs1==ex_rd) | (uses_rs2 & id_rs2==ex_rd)
- Source usage by type:
  - uses_rs1 for R, I, S, B.
  - uses_rs2 for R, S, B, and only when id_b_select=0 or type is S/B.
  - U and J use neither source.
- Per rising edge, priority highest first:
  1. mem_stall=1: all ex_* hold their value; bubble_count holds.
  2. ex_redirect=1: ex_* load the bubble (squashes the wrong-path ID instruction).
  3. load_use=1: ex_* load the bubble; bubble_count increments, saturating at all-ones.
  4. Otherwise: ex_* capture id_*. ex_valid=id_valid, and id_valid=0 is captured as a bubble.
- hold_if_id = mem_stall | load_use.
- flush_if_id = ex_redirect & ~mem_stall.
- Latency: exactly 1 cycle ID to EX. A load-use hazard costs exactly 1 bubble. It clears on the next cycle because the load has moved to MEM.
- Reset asserted mid-stall: state returns to the reset value immediately. There is no pending-hazard memory.

Decomposition:
- Shared package: instruction_type codes (R=000, I=001, S=010, B=011, U=100, J=101), wb_sel encodings, and a BUBBLE constant.
- Sub-module load_use_detect: purely combinational. Inputs are the ID indices/type/b_select and the EX rd/control; output is load_use.

Test Plan:
- lw x5 then add x6,x5,x1 back-to-back -> hold_if_id=1 for one cycle, a bubble reaches EX (ex_valid=0, ex_regfile_enable=0), the add reaches EX next cycle, bubble_count=1.
- lw x0 then add x6,x0,x1 -> no stall, bubble_count unchanged.
- lw x5 then lui x5,0x12345 or jal x5 -> no stall (no rs use).
- Capture of a sw (ex_mem_rw=1, ex_wb_sel=11) while ex_redirect=1 -> ex_* become the bubble and flush_if_id=1. Same case with mem_stall=1 -> ex_* hold and flush_if_id=0.
- Load-use condition coinciding with mem_stall=1 for 3 cycles -> ex_* frozen throughout, hold_if_id=1, bubble inserted only on the first non-stalled edge, count +1.
- Force bubble_count to all-ones, then trigger a load-use -> count stays all-ones. Assert rst asynchronously mid-cycle -> all outputs at reset value before the next edge.
